// File: rtl/mem_bus_pkg.sv
// Shared definitions for the N-channel memory bus: request codes, FSM states
// and the round-robin selection helper.
package mem_bus_pkg;

  localparam int IOSTATE_W = 2;
  localparam logic [IOSTATE_W-1:0] IO_IDLE  = 2'd0;
  localparam logic [IOSTATE_W-1:0] IO_READ  = 2'd1;
  localparam logic [IOSTATE_W-1:0] IO_WRITE = 2'd2;

  localparam int MAX_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // First set bit of req_mask strictly after 'last' in circular order. Unused
  // upper mask bits are zero, so an 8-wide circle orders any smaller N correctly.
  function automatic logic [CH_W-1:0] next_rr(input logic [MAX_CH-1:0] req_mask,
                                               input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] idx;
    next_rr = last;
    for (int i = MAX_CH; i >= 1; i--) begin
      idx = last + CH_W'(i);
      if (req_mask[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/mem_bus_rr_arbiter.sv
// Combinational round-robin arbiter: picks the next requester after last_grant.
module rr_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  input  logic              enable,
  output logic [CH_W-1:0]   grant,
  output logic              valid
);

  logic [MAX_CH-1:0] req_ext;

  always_comb begin
    req_ext             = '0;
    req_ext[NUM_CH-1:0] = req;
  end

  assign grant = next_rr(req_ext, last_grant);
  assign valid = enable && (|req);

endmodule

// File: rtl/mem_bus_rr.sv
// N-channel shared memory bus: round-robin serialised reads/write-backs with a
// fixed access latency. Optional debug ports under MEM_BUS_DEBUG_EN.
module mem_bus_rr
  import mem_bus_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 8,
  parameter int WORD_W  = 16,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*2-1:0]        rwFromCache,
  input  logic [NUM_CH*ADDR_W-1:0]   addrFromCache,
  input  logic [NUM_CH*WORD_W-1:0]   dataFromCache,
  output logic [NUM_CH*WORD_W-1:0]   dataToCache,
  output logic [NUM_CH-1:0]          rdEnToCache,
`ifdef MEM_BUS_DEBUG_EN
  output logic [NUM_CH-1:0]          wbDoneToCache,
  output logic [1:0]                 debugRwToMem,
  output logic [7:0]                 debugDelay
`else
  output logic [NUM_CH-1:0]          wbDoneToCache
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t                state, state_nxt;
  logic [CH_W-1:0]       last_grant, grant, cur_ch;
  logic                  grant_valid;
  logic [NUM_CH-1:0]     req, ch_onehot;
  logic [IOSTATE_W-1:0]  cur_rw, sel_rw;
  logic [ADDR_W-1:0]     cur_addr, sel_addr;
  logic [WORD_W-1:0]     cur_data, sel_data;
  logic [7:0]            cnt;
  logic                  load, dec, finish;

  // Zero at time 0 only; reset deliberately leaves contents alone.
  logic [WORD_W-1:0]     mem [DEPTH] = '{default: '0};

  // A channel still holding its level during its done cycle is masked out.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i] = (rwFromCache[2*i +: 2] == IO_READ || rwFromCache[2*i +: 2] == IO_WRITE)
               && !(rdEnToCache[i] || wbDoneToCache[i]);
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (req),
    .last_grant (last_grant),
    .enable     (state == S_IDLE),
    .grant      (grant),
    .valid      (grant_valid)
  );

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel_rw   = IO_IDLE;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_W'(i)) begin
        sel_rw   = rwFromCache[2*i +: 2];
        sel_addr = addrFromCache[ADDR_W*i +: ADDR_W];
        sel_data = dataFromCache[WORD_W*i +: WORD_W];
      end
    end
  end

  always_comb begin
    ch_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) ch_onehot[i] = (cur_ch == CH_W'(i));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_valid) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == '0)   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load   = (state == S_IDLE) && grant_valid;
    dec    = (state == S_BUSY) && (cnt != '0);
    finish = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      last_grant    <= CH_W'(NUM_CH - 1);
      cur_ch        <= '0;
      cur_rw        <= IO_IDLE;
      cur_addr      <= '0;
      cur_data      <= '0;
      rdEnToCache   <= '0;
      wbDoneToCache <= '0;
      dataToCache   <= '0;
    end else begin
      rdEnToCache   <= (finish && cur_rw == IO_READ)  ? ch_onehot : '0;
      wbDoneToCache <= (finish && cur_rw == IO_WRITE) ? ch_onehot : '0;
      if (load) begin
        cur_ch   <= grant;
        cur_rw   <= sel_rw;
        cur_addr <= sel_addr;
        cur_data <= sel_data;
        cnt      <= 8'(LATENCY - 1);
      end else if (dec) begin
        cnt <= cnt - 8'd1;
      end
      if (finish) last_grant <= cur_ch;
      for (int i = 0; i < NUM_CH; i++) begin
        if (finish && cur_rw == IO_READ && ch_onehot[i])
          dataToCache[WORD_W*i +: WORD_W] <= mem[cur_addr];
      end
    end
  end

  // NOTE: the memory array has no reset branch, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (finish && cur_rw == IO_WRITE) mem[cur_addr] <= cur_data;
  end

`ifdef MEM_BUS_DEBUG_EN
  assign debugRwToMem = (state == S_IDLE) ? IO_IDLE : cur_rw;
  assign debugDelay   = cnt;
`endif

endmodule

// File: tb/tb_mem_bus_rr.sv
// Self-checking bench for mem_bus_rr (NUM_CH=4, LATENCY=4) against a
// transaction-level model: pending set, round-robin pick, grant-order memory.
module tb_mem_bus_rr;
  import mem_bus_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int WW  = 16;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2*NCH-1:0]  rw_bus = '0;
  logic [AW*NCH-1:0] addr_bus = '0;
  logic [WW*NCH-1:0] wdata_bus = '0;
  logic [WW*NCH-1:0] rdata_bus;
  logic [NCH-1:0]    rd_en, wb_done;
`ifdef MEM_BUS_DEBUG_EN
  logic [1:0]        dbg_rw;
  logic [7:0]        dbg_delay;
`endif

  mem_bus_rr #(.NUM_CH(NCH), .ADDR_W(AW), .WORD_W(WW), .LATENCY(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .rwFromCache   (rw_bus),
    .addrFromCache (addr_bus),
    .dataFromCache (wdata_bus),
    .dataToCache   (rdata_bus),
    .rdEnToCache   (rd_en),
`ifdef MEM_BUS_DEBUG_EN
    .wbDoneToCache (wb_done),
    .debugRwToMem  (dbg_rw),
    .debugDelay    (dbg_delay)
`else
    .wbDoneToCache (wb_done)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [WW-1:0] mmem [2**AW];
  logic [WW-1:0] exp_dout [NCH];
  bit            pend [NCH];
  int            samp [NCH];
  logic [1:0]    pop [NCH];
  logic [AW-1:0] paddr [NCH];
  logic [WW-1:0] pdata [NCH];
  int            drop_at [NCH];
  int            ready_at [NCH];
  int            last_ch, free_edge, pred_ch, pred_cyc;
  bit            have_pred;
  bit            auto_mode, continuous, rand_drop;
  int            served [$];
  int            done_cycs [$];
  int            obs_done_cyc;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    rw_bus = '0;
    for (int i = 0; i < NCH; i++) begin
      pend[i] = 0; exp_dout[i] = '0; drop_at[i] = -1; ready_at[i] = 0;
    end
    have_pred = 0;
    last_ch   = NCH - 1;
  endtask

  task automatic issue(input int ch, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [WW-1:0] d);
    rw_bus[2*ch +: 2]     = op;
    addr_bus[AW*ch +: AW] = a;
    wdata_bus[WW*ch +: WW] = d;
    pend[ch] = 1; samp[ch] = cyc + 1;
    pop[ch] = op; paddr[ch] = a; pdata[ch] = d;
  endtask

  // Decide the next grant once the sampling edge is the very next edge.
  task automatic finalize();
    int kmin, k, c;
    bit any, found;
    any = 0; kmin = 32'h7fffffff;
    for (int i = 0; i < NCH; i++)
      if (pend[i]) begin any = 1; if (samp[i] < kmin) kmin = samp[i]; end
    if (!have_pred && any) begin
      k = (free_edge > kmin) ? free_edge : kmin;
      if (k == cyc + 1) begin
        found = 0;
        for (int j = 1; j <= NCH; j++) begin
          c = (last_ch + j) % NCH;
          if (!found && pend[c] && samp[c] <= k) begin pred_ch = c; found = 1; end
        end
        pred_cyc  = k + LAT + 1;
        have_pred = 1;
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0]    exp_rd, exp_wb, obs_any;
    logic [WW*NCH-1:0] exp_bus;
    bit                done_now;
    finalize();
    @(negedge clk);
    for (int i = 0; i < NCH; i++)
      if (drop_at[i] == cyc) rw_bus[2*i +: 2] = IO_IDLE;
    exp_rd = '0; exp_wb = '0;
    done_now = have_pred && (cyc == pred_cyc);
    if (done_now) begin
      if (pop[pred_ch] == IO_READ) begin
        exp_rd[pred_ch]   = 1'b1;
        exp_dout[pred_ch] = mmem[paddr[pred_ch]];
      end else begin
        exp_wb[pred_ch]      = 1'b1;
        mmem[paddr[pred_ch]] = pdata[pred_ch];
      end
    end
    for (int i = 0; i < NCH; i++) exp_bus[WW*i +: WW] = exp_dout[i];
    chk("rd_en", 64'(rd_en), 64'(exp_rd));
    chk("wb_done", 64'(wb_done), 64'(exp_wb));
    chk("data_to_cache", 64'(rdata_bus), 64'(exp_bus));
    obs_any = rd_en | wb_done;
    if (obs_any != '0) begin
      obs_done_cyc = cyc;
      done_cycs.push_back(cyc);
      for (int i = NCH - 1; i >= 0; i--)
        if (obs_any[i]) begin served.push_back(i); break; end
    end
    if (done_now) begin
      pend[pred_ch]     = 0;
      last_ch           = pred_ch;
      free_edge         = cyc + 1;
      have_pred         = 0;
      drop_at[pred_ch]  = cyc + 1;
      ready_at[pred_ch] = cyc + 2;
    end
    if (rand_drop && have_pred && cyc >= pred_cyc - LAT - 1 && $urandom_range(0, 7) == 0)
      rw_bus[2*pred_ch +: 2] = IO_IDLE;
    if (auto_mode)
      for (int i = 0; i < NCH; i++)
        if (!pend[i] && cyc >= ready_at[i] && (continuous || $urandom_range(0, 3) == 0))
          issue(i, ($urandom_range(0, 1) == 0) ? IO_READ : IO_WRITE,
                AW'($urandom_range(0, 15)), WW'($urandom));
  endtask

  function automatic bit model_busy();
    model_busy = have_pred;
    for (int i = 0; i < NCH; i++) if (pend[i]) model_busy = 1;
  endfunction

  task automatic drain();
    int b;
    b = 0;
    while (model_busy() && b < 400) begin step(); b++; end
    chk("drain_timeout", 64'(model_busy()), 64'd0);
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    @(negedge clk);
    chk("reset_rd_en", 64'(rd_en), 64'd0);
    chk("reset_wb_done", 64'(wb_done), 64'd0);
    chk("reset_data", 64'(rdata_bus), 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    free_edge = cyc + 1;
  endtask

  initial begin
    int s, n0, b;
    for (int i = 0; i < 2**AW; i++) mmem[i] = '0;
    auto_mode = 0; continuous = 0; rand_drop = 0; obs_done_cyc = -1;
    clear_model();
    @(negedge clk);
    do_reset();

    // Single write: latency and stored value
    issue(0, IO_WRITE, 8'd0, 16'd3);
    s = cyc + 1;
    drain();
    chk("t1_write_latency", 64'(obs_done_cyc - s), 64'(LAT + 1));
    issue(0, IO_READ, 8'd0, 16'd0);
    drain();
    chk("t1_readback", 64'(rdata_bus[WW-1:0]), 64'd3);

    // Simultaneous writes to the same address
    do_reset();
    n0 = served.size();
    issue(0, IO_WRITE, 8'd0, 16'd3);
    issue(1, IO_WRITE, 8'd0, 16'd4);
    drain();
    chk("t2_first", 64'(served[n0]), 64'd0);
    chk("t2_second", 64'(served[n0+1]), 64'd1);
    issue(0, IO_READ, 8'd0, 16'd0);
    drain();
    chk("t2_readback", 64'(rdata_bus[WW-1:0]), 64'd4);

    // Write then read of the same address, same cycle
    do_reset();
    issue(0, IO_WRITE, 8'd0, 16'd3);
    issue(1, IO_READ, 8'd0, 16'd0);
    s = cyc + 1;
    drain();
    chk("t3_read_latency", 64'(obs_done_cyc - s), 64'(2 * (LAT + 2) - 1));
    chk("t3_read_data", 64'(rdata_bus[WW +: WW]), 64'd3);

    // All channels requesting continuously
    do_reset();
    n0 = served.size();
    auto_mode = 1; continuous = 1;
    b = 0;
    while (served.size() < n0 + 8 && b < 300) begin step(); b++; end
    auto_mode = 0; continuous = 0;
    chk("t4_timeout", 64'(served.size() >= n0 + 8), 64'd1);
    drain();
    for (int i = 0; i < 8; i++) chk("t4_order", 64'(served[n0+i]), 64'(i % NCH));
    for (int i = 1; i < 8; i++)
      chk("t4_gap", 64'(done_cycs[n0+i] - done_cycs[n0+i-1]), 64'(LAT + 2));

    // Reset aborts an in-flight write
    issue(0, IO_WRITE, 8'd5, 16'h0055);
    drain();
    issue(1, IO_WRITE, 8'd5, 16'd7);
    b = 0;
    while (!have_pred && b < 50) begin step(); b++; end
    step(); step();
    n0 = served.size();
    do_reset();
    repeat (LAT + 4) step();
    chk("t5_no_done", 64'(served.size() - n0), 64'd0);
    issue(2, IO_READ, 8'd5, 16'd0);
    issue(0, IO_READ, 8'd5, 16'd0);
    drain();
    chk("t5_first_after_reset", 64'(served[n0]), 64'd0);
    chk("t5_mem_unchanged", 64'(rdata_bus[WW-1:0]), 64'h55);

    // Requester drops its level after grant
    issue(3, IO_WRITE, 8'd9, 16'hBEEF);
    drain();
    n0 = served.size();
    issue(1, IO_READ, 8'd9, 16'd0);
    b = 0;
    while (!have_pred && b < 50) begin step(); b++; end
    step(); step();
    rw_bus[3:2] = IO_IDLE;
    drain();
    repeat (LAT + 4) step();
    chk("t6_single_done", 64'(served.size() - n0), 64'd1);
    chk("t6_data", 64'(rdata_bus[WW +: WW]), 64'hBEEF);

    // Randomised traffic
    auto_mode = 1; rand_drop = 1;
    repeat (500) step();
    auto_mode = 0; rand_drop = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_rr.md
# mem_bus_rr

Parametrised N-channel shared memory bus: the next generation of the two-port cache-to-memory bus. It sits between N private caches and one word-addressed backing memory array. It serialises read-miss fills and write-backs with round-robin arbitration and a programmable access latency. Each channel sees the same level-request / one-cycle-done handshake the caches already use.

## Interface
- NUM_CH, default 2: number of cache channels, 2..8
- ADDR_W, default 8: address width; memory depth is 2**ADDR_W words
- WORD_W, default 16: data word width
- LATENCY, default 4: memory access cycles, 1..255
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- rwFromCache  in  NUM_CH*2  per-channel request code; channel i in bits [2i+1:2i]
- addrFromCache  in  NUM_CH*ADDR_W  per-channel address
- dataFromCache  in  NUM_CH*WORD_W  per-channel write-back data
- dataToCache  out  NUM_CH*WORD_W  per-channel read data
- rdEnToCache  out  NUM_CH  one-cycle read-done pulse
- wbDoneToCache  out  NUM_CH  one-cycle write-done pulse
- debugRwToMem  out  2  code of transaction in flight (only with MEM_BUS_DEBUG_EN)
- debugDelay  out  8  remaining latency count (only with MEM_BUS_DEBUG_EN)

## Operation
- Request codes: IO_IDLE=2'd0, IO_READ=2'd1, IO_WRITE=2'd2; 2'd3 is treated as IO_IDLE.
- A requester holds rw/addr/data stable until it receives its done pulse. It drives IO_IDLE in the cycle after done.
- The FSM has three states: S_IDLE, S_BUSY, S_DONE.
- S_IDLE: if any channel is requesting, grant the next requester after lastGrant in circular order. Latch its channel, code, address and data, load cnt=LATENCY-1, and go to S_BUSY.
- S_BUSY: decrement cnt. When cnt==0, go to S_DONE.
- S_DONE: for a read, drive dataToCache[ch]=mem[addr] and pulse rdEnToCache[ch]. For a write, set mem[addr]=data and pulse wbDoneToCache[ch]. Set lastGrant=ch and return to S_IDLE.
- The channel just served is masked from arbitration in the S_IDLE cycle that follows its done. This prevents a stale level from being re-granted.
- Once granted, a transaction always completes. Dropping rw mid-transaction has no effect.
- dataToCache[ch] holds its last read value until the next read done on that channel.
- Same-address read and write from different channels are serialised strictly in grant order. A read granted after a write returns the new data.
- Memory has no out-of-range case: the full 2**ADDR_W space is valid.

## Timing
- Reset values: dataToCache=0, rdEnToCache=0, wbDoneToCache=0, state=S_IDLE, lastGrant=NUM_CH-1 (so channel 0 wins first), cnt=0, debugRwToMem=IO_IDLE, debugDelay=0.
- Memory contents are not cleared by reset; they are zero-initialised at time 0.
- Latency: a request sampled in S_IDLE at edge k produces its done pulse in the cycle after edge k+LATENCY+1.
- Throughput: one transaction per LATENCY+2 cycles.
- Every done pulse is exactly one cycle wide. At most one channel receives a done pulse in any cycle.
- Reset asserted mid-transaction aborts it: no memory write and no done pulse. Arbitration restarts from channel 0 after release.
- With all channels requesting continuously, service order is 0,1,…,NUM_CH-1,0,… No channel waits more than NUM_CH-1 transactions.

## Configuration
- MEM_BUS_DEBUG_EN defined: debugRwToMem and debugDelay ports exist.
  - debugRwToMem shows the latched code in S_BUSY/S_DONE and IO_IDLE otherwise.
  - debugDelay shows cnt zero-extended to 8 bits.
- MEM_BUS_DEBUG_EN undefined: both ports and their logic are absent. Functional behaviour is identical.

## Structure
- Package mem_bus_pkg holds:
  - IO_IDLE, IO_READ, IO_WRITE and IOSTATE_W=2
  - state enum {S_IDLE, S_BUSY, S_DONE}
  - function next_rr(req_mask, last) returning the next granted index
- One sub-module, rr_arbiter (parameter NUM_CH):
  - inputs: req vector, lastGrant, enable
  - outputs: grant index, valid
  - purely combinational
- The top level owns the FSM, latency counter, memory array and output registers.

## Test plan
- NUM_CH=2, LATENCY=4: ch0 WRITE addr0 data 3 -> wbDoneToCache[0] pulses 6 cycles after sampling, mem[0]=3.
- Both channels WRITE addr0 simultaneously (ch0 data 3, ch1 data 4) -> ch0 done first, ch1 second, mem[0]=4.
- ch0 WRITE addr0=3, ch1 READ addr0 in the same cycle -> ch1 dataToCache=3 with rdEnToCache[1] 12 cycles after sampling.
- NUM_CH=4, all channels requesting continuously for 8 transactions -> done order 0,1,2,3,0,1,2,3, no gaps beyond LATENCY+2.
- Reset asserted 2 cycles into a WRITE of 7 to addr5 -> no done pulse, mem[5] unchanged, channel 0 granted first after release.
- ch1 requests READ and drops rw to IO_IDLE after grant -> rdEnToCache[1] still pulses once with mem data, and the channel is not re-granted.
